// File: rtl/rx_pkt_gate.sv
// RX packet gate: buffers fixed-length modem packets in a ping-pong store and
// forwards only those whose CRC verdict is good, with ok/drop/truncation stats.
module rx_pkt_gate #(
  parameter int unsigned PKT_LEN = 64,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk_hh,
  input  logic             aresetn,
  input  logic [7:0]       s_axis_tdata,
  input  logic             s_axis_tvalid,
  input  logic             s_axis_tuser,
  output logic             s_axis_tready,
  input  logic             sts_valid,
  input  logic             sts_err,
  output logic [7:0]       m_axis_tdata,
  output logic             m_axis_tvalid,
  output logic             m_axis_tlast,
  input  logic             m_axis_tready,
  output logic [CNT_W-1:0] pkt_ok_cnt,
  output logic [CNT_W-1:0] pkt_drop_cnt,
  output logic [CNT_W-1:0] pkt_trunc_cnt
);

  localparam int unsigned IW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(PKT_LEN - 1);

  typedef enum logic [1:0] {
    HUNT     = 2'd0,
    FILL     = 2'd1,
    WAIT_STS = 2'd2
  } wr_state_e;

  logic [7:0] mem [2][PKT_LEN];

  wr_state_e         state_q, state_d;
  logic [IW-1:0]     wr_cnt_q, wr_cnt_d;
  logic              wr_bank_q, wr_bank_d;
  logic              rd_bank_q, rd_bank_d;
  logic              fetch_bank_q, fetch_bank_d;
  logic [IW-1:0]     rd_idx_q, rd_idx_d;
  logic [1:0]        full_q, full_d;
  logic              tready_d;
  logic              tvalid_d, tlast_d;
  logic [7:0]        tdata_d;
  logic [CNT_W-1:0]  ok_d, drop_d, trunc_d;
  logic              s_hs, commit, wr_en;
  logic [IW-1:0]     wr_idx;

  // Bank storage; no reset, the bank flags alone say what is valid
  always_ff @(posedge clk_hh) begin
    if (wr_en) mem[wr_bank_q][wr_idx] <= s_axis_tdata;
  end

  always_ff @(posedge clk_hh) begin
    if (!aresetn) begin
      state_q       <= HUNT;
      wr_cnt_q      <= '0;
      wr_bank_q     <= 1'b0;
      rd_bank_q     <= 1'b0;
      fetch_bank_q  <= 1'b0;
      rd_idx_q      <= '0;
      full_q        <= '0;
      s_axis_tready <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdata  <= '0;
      pkt_ok_cnt    <= '0;
      pkt_drop_cnt  <= '0;
      pkt_trunc_cnt <= '0;
    end else begin
      state_q       <= state_d;
      wr_cnt_q      <= wr_cnt_d;
      wr_bank_q     <= wr_bank_d;
      rd_bank_q     <= rd_bank_d;
      fetch_bank_q  <= fetch_bank_d;
      rd_idx_q      <= rd_idx_d;
      full_q        <= full_d;
      s_axis_tready <= tready_d;
      m_axis_tvalid <= tvalid_d;
      m_axis_tlast  <= tlast_d;
      m_axis_tdata  <= tdata_d;
      pkt_ok_cnt    <= ok_d;
      pkt_drop_cnt  <= drop_d;
      pkt_trunc_cnt <= trunc_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    wr_cnt_d     = wr_cnt_q;
    wr_bank_d    = wr_bank_q;
    rd_bank_d    = rd_bank_q;
    fetch_bank_d = fetch_bank_q;
    rd_idx_d     = rd_idx_q;
    full_d       = full_q;
    tvalid_d     = m_axis_tvalid;
    tlast_d      = m_axis_tlast;
    tdata_d      = m_axis_tdata;
    ok_d         = pkt_ok_cnt;
    drop_d       = pkt_drop_cnt;
    trunc_d      = pkt_trunc_cnt;
    wr_en        = 1'b0;
    wr_idx       = '0;
    commit       = 1'b0;
    s_hs         = s_axis_tvalid & s_axis_tready;

    // Write side: hunt for SOP, fill the bank, then wait for the CRC verdict
    case (state_q)
      HUNT: begin
        if (s_hs && s_axis_tuser) begin
          wr_en    = 1'b1;
          wr_cnt_d = IW'(1);
          state_d  = FILL;
        end
      end
      FILL: begin
        if (s_hs) begin
          wr_en = 1'b1;
          if (s_axis_tuser) begin
            wr_cnt_d = IW'(1);
            trunc_d  = pkt_trunc_cnt + CNT_W'(1);
          end else begin
            wr_idx = wr_cnt_q;
            if (wr_cnt_q == LAST_IDX) begin
              wr_cnt_d = '0;
              state_d  = WAIT_STS;
            end else begin
              wr_cnt_d = wr_cnt_q + IW'(1);
            end
          end
        end
      end
      WAIT_STS: begin
        if (sts_valid) begin
          state_d = HUNT;
          if (sts_err) begin
            drop_d = pkt_drop_cnt + CNT_W'(1);
          end else begin
            commit    = 1'b1;
            wr_bank_d = ~wr_bank_q;
            ok_d      = pkt_ok_cnt + CNT_W'(1);
          end
        end
      end
      default: state_d = HUNT;
    endcase

    // Free on the tlast handshake first so a same-cycle commit wins
    if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
    end
    if (commit) full_d[wr_bank_q] = 1'b1;

    // Read side: fetch pointer runs at most one byte ahead of the output register
    if (!m_axis_tvalid || m_axis_tready) begin
      if (full_q[fetch_bank_q]) begin
        tvalid_d = 1'b1;
        tdata_d  = mem[fetch_bank_q][rd_idx_q];
        tlast_d  = (rd_idx_q == LAST_IDX);
        if (rd_idx_q == LAST_IDX) begin
          rd_idx_d     = '0;
          fetch_bank_d = ~fetch_bank_q;
        end else begin
          rd_idx_d = rd_idx_q + IW'(1);
        end
      end else begin
        tvalid_d = 1'b0;
        tlast_d  = 1'b0;
      end
    end

    tready_d = (state_d == FILL) || ((state_d == HUNT) && !full_d[wr_bank_d]);
  end

endmodule

// File: tb/tb_rx_pkt_gate.sv
// Self-checking bench for rx_pkt_gate: directed scenarios plus a randomized
// packet run scored against a packet-level model of what must come out.
module tb_rx_pkt_gate;

  localparam int unsigned PKT_LEN = 4;
  localparam int unsigned CNT_W   = 8;

  logic             clk_hh = 1'b0;
  logic             aresetn = 1'b0;
  logic [7:0]       s_axis_tdata = '0;
  logic             s_axis_tvalid = 1'b0;
  logic             s_axis_tuser = 1'b0;
  logic             s_axis_tready;
  logic             sts_valid = 1'b0;
  logic             sts_err = 1'b0;
  logic [7:0]       m_axis_tdata;
  logic             m_axis_tvalid;
  logic             m_axis_tlast;
  logic             m_axis_tready = 1'b0;
  logic [CNT_W-1:0] pkt_ok_cnt, pkt_drop_cnt, pkt_trunc_cnt;

  rx_pkt_gate #(.PKT_LEN(PKT_LEN), .CNT_W(CNT_W)) dut (
    .clk_hh        (clk_hh),
    .aresetn       (aresetn),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tready (s_axis_tready),
    .sts_valid     (sts_valid),
    .sts_err       (sts_err),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .pkt_ok_cnt    (pkt_ok_cnt),
    .pkt_drop_cnt  (pkt_drop_cnt),
    .pkt_trunc_cnt (pkt_trunc_cnt)
  );

  always #5 clk_hh = ~clk_hh;

  int         vecs = 0;
  int         fails = 0;
  int         cyc = 0;
  int         stab_viol = 0;
  int         ok_m = 0, drop_m = 0, trunc_m = 0;
  logic [8:0] exp_q[$];
  logic [8:0] got_q[$];
  int         got_cyc[$];
  logic [7:0] pkt_buf [PKT_LEN];
  bit         rand_rdy = 1'b0;
  logic       force_rdy = 1'b1;
  bit         hold_prev = 1'b0;
  logic [8:0] prev_out = '0;

  // Downstream ready: random or forced, changed just after the edge
  always @(posedge clk_hh) begin
    cyc++;
    #1 m_axis_tready = rand_rdy ? 1'($urandom_range(0, 1)) : force_rdy;
  end

  // Output monitor: records handshakes and flags any change while stalled
  always @(negedge clk_hh) begin
    if (!aresetn) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev && (!m_axis_tvalid || {m_axis_tlast, m_axis_tdata} !== prev_out))
        stab_viol++;
      if (m_axis_tvalid && m_axis_tready) begin
        got_q.push_back({m_axis_tlast, m_axis_tdata});
        got_cyc.push_back(cyc);
      end
      hold_prev = m_axis_tvalid && !m_axis_tready;
      prev_out  = {m_axis_tlast, m_axis_tdata};
    end
  end

  initial begin
    #(10 * 90000);
    $display("FAIL watchdog: simulation still running at cycle %0d, required finish", cyc);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_hh);
    #1;
  endtask

  task automatic put_byte(input logic [7:0] d, input logic u, input bit spur);
    int n;
    n = 0;
    s_axis_tdata  = d;
    s_axis_tuser  = u;
    s_axis_tvalid = 1'b1;
    if (spur) begin
      sts_valid = 1'b1;
      sts_err   = 1'($urandom_range(0, 1));
    end
    do begin
      @(negedge clk_hh);
      n++;
    end while (s_axis_tready !== 1'b1 && n < 2000);
    if (s_axis_tready !== 1'b1) begin
      vecs++;
      fails++;
      $display("FAIL input_stall: s_axis_tready=%b after %0d cycles, required 1", s_axis_tready, n);
    end
    tick();
    s_axis_tvalid = 1'b0;
    s_axis_tuser  = 1'b0;
    sts_valid     = 1'b0;
    sts_err       = 1'b0;
  endtask

  task automatic send_status(input logic err);
    sts_valid = 1'b1;
    sts_err   = err;
    tick();
    sts_valid = 1'b0;
    sts_err   = 1'b0;
  endtask

  // st: 0 = truncated (next packet's SOP interrupts it), 1 = CRC good, 2 = CRC bad
  task automatic send_pkt(input int n, input int st, input bit rnd);
    for (int i = 0; i < n; i++) begin
      if (rnd && i > 0 && $urandom_range(0, 3) == 0) tick();
      put_byte(pkt_buf[i], (i == 0), rnd && i > 0 && $urandom_range(0, 7) == 0);
    end
    if (st == 0) begin
      trunc_m++;
    end else begin
      if (rnd) repeat ($urandom_range(0, 2)) tick();
      send_status(st == 2);
      if (st == 1) begin
        ok_m++;
        for (int i = 0; i < PKT_LEN; i++) exp_q.push_back({(i == PKT_LEN - 1), pkt_buf[i]});
      end else begin
        drop_m++;
      end
    end
  endtask

  task automatic fill_buf(input logic [7:0] base);
    for (int i = 0; i < PKT_LEN; i++) pkt_buf[i] = base + 8'(i);
  endtask

  task automatic wait_got(input int n, input int lim, output bit ok);
    int k;
    k = 0;
    while (got_q.size() < n && k < lim) begin
      tick();
      k++;
    end
    ok = (got_q.size() >= n);
  endtask

  task automatic clear_q();
    exp_q.delete();
    got_q.delete();
    got_cyc.delete();
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    repeat (3) tick();
    vecs++; if (m_axis_tvalid !== 1'b0) begin fails++; $display("FAIL rst_tvalid: got %b want 0", m_axis_tvalid); end
    vecs++; if (m_axis_tlast !== 1'b0) begin fails++; $display("FAIL rst_tlast: got %b want 0", m_axis_tlast); end
    vecs++; if (m_axis_tdata !== 8'h00) begin fails++; $display("FAIL rst_tdata: got %h want 00", m_axis_tdata); end
    vecs++; if (s_axis_tready !== 1'b0) begin fails++; $display("FAIL rst_s_tready: got %b want 0", s_axis_tready); end
    vecs++; if ({pkt_ok_cnt, pkt_drop_cnt, pkt_trunc_cnt} !== '0) begin
      fails++; $display("FAIL rst_counters: got %h/%h/%h want 0/0/0", pkt_ok_cnt, pkt_drop_cnt, pkt_trunc_cnt);
    end
    aresetn = 1'b1;
    tick();
    vecs++; if (s_axis_tready !== 1'b1) begin fails++; $display("FAIL hunt_ready: got %b want 1", s_axis_tready); end
  endtask

  task automatic test_good();
    int k;
    bit ok;
    clear_q();
    force_rdy = 1'b1;
    fill_buf(8'hA0);
    send_pkt(PKT_LEN, 1, 1'b0);
    k = 0;
    while (m_axis_tvalid !== 1'b1 && k < 6) begin
      tick();
      k++;
    end
    vecs++; if (k > 3) begin fails++; $display("FAIL first_valid_latency: got %0d cycles want <=3", k); end
    wait_got(exp_q.size(), 100, ok);
    repeat (4) tick();
    vecs++; if (got_q.size() !== exp_q.size()) begin fails++; $display("FAIL good_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      vecs++; if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL good_byte[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    vecs++; if (pkt_ok_cnt !== CNT_W'(ok_m)) begin fails++; $display("FAIL good_ok_cnt: got %0d want %0d", pkt_ok_cnt, ok_m); end
  endtask

  task automatic test_crc_err();
    bit ok;
    clear_q();
    fill_buf(8'hA0);
    send_pkt(PKT_LEN, 2, 1'b0);
    fill_buf(8'hB0);
    send_pkt(PKT_LEN, 1, 1'b0);
    wait_got(exp_q.size(), 100, ok);
    repeat (4) tick();
    vecs++; if (got_q.size() !== exp_q.size()) begin fails++; $display("FAIL crc_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      vecs++; if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL crc_byte[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    vecs++; if (pkt_drop_cnt !== CNT_W'(drop_m)) begin fails++; $display("FAIL crc_drop_cnt: got %0d want %0d", pkt_drop_cnt, drop_m); end
  endtask

  task automatic test_trunc();
    bit ok;
    clear_q();
    fill_buf(8'hA0);
    send_pkt(2, 0, 1'b0);
    fill_buf(8'hB0);
    send_pkt(PKT_LEN, 1, 1'b0);
    wait_got(exp_q.size(), 100, ok);
    repeat (4) tick();
    vecs++; if (got_q.size() !== exp_q.size()) begin fails++; $display("FAIL trunc_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      vecs++; if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL trunc_byte[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    vecs++; if (pkt_trunc_cnt !== CNT_W'(trunc_m)) begin fails++; $display("FAIL trunc_cnt: got %0d want %0d", pkt_trunc_cnt, trunc_m); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    bit gap;
    clear_q();
    stab_viol = 0;
    force_rdy = 1'b0;
    repeat (2) tick();
    fill_buf(8'hC0);
    send_pkt(PKT_LEN, 1, 1'b0);
    fill_buf(8'hD0);
    send_pkt(PKT_LEN, 1, 1'b0);
    repeat (3) tick();
    vecs++; if (s_axis_tready !== 1'b0) begin fails++; $display("FAIL bp_s_tready: got %b want 0", s_axis_tready); end
    vecs++; if ({m_axis_tvalid, m_axis_tdata} !== {1'b1, 8'hC0}) begin
      fails++; $display("FAIL bp_held: got v=%b d=%h want v=1 d=c0", m_axis_tvalid, m_axis_tdata);
    end
    fill_buf(8'hE0);
    fork
      send_pkt(PKT_LEN, 1, 1'b0);
      begin
        repeat (6) tick();
        vecs++; if (got_q.size() !== 0) begin fails++; $display("FAIL bp_leak: got %0d bytes want 0", got_q.size()); end
        vecs++; if (s_axis_tready !== 1'b0) begin fails++; $display("FAIL bp_s_tready_hold: got %b want 0", s_axis_tready); end
        force_rdy = 1'b1;
      end
    join
    wait_got(exp_q.size(), 200, ok);
    repeat (4) tick();
    vecs++; if (got_q.size() !== 3 * PKT_LEN) begin fails++; $display("FAIL bp_count: got %0d want %0d", got_q.size(), 3 * PKT_LEN); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      vecs++; if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL bp_byte[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    gap = 1'b0;
    for (int i = 0; i + 1 < 2 * PKT_LEN && i + 1 < got_cyc.size(); i++)
      if (got_cyc[i + 1] != got_cyc[i] + 1) gap = 1'b1;
    vecs++; if (gap !== 1'b0 || got_cyc.size() < 2 * PKT_LEN) begin
      fails++; $display("FAIL bp_throughput: bubble=%b across banks, want one byte per cycle", gap);
    end
    vecs++; if (stab_viol !== 0) begin fails++; $display("FAIL bp_stable: got %0d changes while stalled want 0", stab_viol); end
    vecs++; if (pkt_ok_cnt !== CNT_W'(ok_m)) begin fails++; $display("FAIL bp_ok_cnt: got %0d want %0d", pkt_ok_cnt, ok_m); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    clear_q();
    force_rdy = 1'b1;
    fill_buf(8'h30);
    send_pkt(PKT_LEN, 1, 1'b0);
    wait_got(2, 50, ok);
    vecs++; if (!ok || m_axis_tdata !== 8'h32) begin fails++; $display("FAIL rm_third: got %h want 32", m_axis_tdata); end
    aresetn = 1'b0;
    tick();
    vecs++; if (m_axis_tvalid !== 1'b0) begin fails++; $display("FAIL rm_tvalid: got %b want 0", m_axis_tvalid); end
    vecs++; if ({pkt_ok_cnt, pkt_drop_cnt, pkt_trunc_cnt} !== '0) begin
      fails++; $display("FAIL rm_counters: got %h/%h/%h want 0/0/0", pkt_ok_cnt, pkt_drop_cnt, pkt_trunc_cnt);
    end
    tick();
    aresetn = 1'b1;
    ok_m = 0; drop_m = 0; trunc_m = 0;
    repeat (10) tick();
    vecs++; if (got_q.size() !== 2) begin fails++; $display("FAIL rm_after_reset: got %0d bytes want 2", got_q.size()); end
    // reset in the middle of filling, then a clean packet
    clear_q();
    fill_buf(8'h50);
    send_pkt(2, 0, 1'b0);
    aresetn = 1'b0;
    repeat (2) tick();
    aresetn = 1'b1;
    ok_m = 0; drop_m = 0; trunc_m = 0;
    fill_buf(8'h60);
    send_pkt(PKT_LEN, 1, 1'b0);
    wait_got(exp_q.size(), 100, ok);
    repeat (4) tick();
    vecs++; if (got_q.size() !== exp_q.size()) begin fails++; $display("FAIL rm_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      vecs++; if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL rm_byte[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    vecs++; if ({pkt_ok_cnt, pkt_trunc_cnt} !== {CNT_W'(ok_m), CNT_W'(trunc_m)}) begin
      fails++; $display("FAIL rm_cnt: got ok=%0d trunc=%0d want ok=%0d trunc=%0d", pkt_ok_cnt, pkt_trunc_cnt, ok_m, trunc_m);
    end
  endtask

  task automatic test_random();
    bit ok;
    bit after_trunc;
    int kind;
    int nerr;
    clear_q();
    stab_viol = 0;
    rand_rdy = 1'b1;
    after_trunc = 1'b0;
    for (int p = 0; p < 1000; p++) begin
      if (!after_trunc && $urandom_range(0, 4) == 0) put_byte(8'($urandom), 1'b0, 1'b0);
      for (int i = 0; i < PKT_LEN; i++) pkt_buf[i] = 8'($urandom);
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        send_pkt(PKT_LEN, 2, 1'b1);
        after_trunc = 1'b0;
      end else if (kind == 1 && p < 999) begin
        send_pkt($urandom_range(1, PKT_LEN - 1), 0, 1'b1);
        after_trunc = 1'b1;
      end else begin
        send_pkt(PKT_LEN, 1, 1'b1);
        after_trunc = 1'b0;
      end
    end
    rand_rdy = 1'b0;
    force_rdy = 1'b1;
    wait_got(exp_q.size(), 20000, ok);
    repeat (8) tick();
    vecs++; if (got_q.size() !== exp_q.size()) begin fails++; $display("FAIL rnd_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    nerr = 0;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      vecs++;
      if (got_q[i] !== exp_q[i]) begin
        fails++;
        nerr++;
        $display("FAIL rnd_byte[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
    vecs++; if (stab_viol !== 0) begin fails++; $display("FAIL rnd_stable: got %0d changes while stalled want 0", stab_viol); end
    vecs++; if (pkt_ok_cnt !== CNT_W'(ok_m)) begin fails++; $display("FAIL rnd_ok_cnt: got %0d want %0d", pkt_ok_cnt, CNT_W'(ok_m)); end
    vecs++; if (pkt_drop_cnt !== CNT_W'(drop_m)) begin fails++; $display("FAIL rnd_drop_cnt: got %0d want %0d", pkt_drop_cnt, CNT_W'(drop_m)); end
    vecs++; if (pkt_trunc_cnt !== CNT_W'(trunc_m)) begin fails++; $display("FAIL rnd_trunc_cnt: got %0d want %0d", pkt_trunc_cnt, CNT_W'(trunc_m)); end
  endtask

  initial begin
    test_reset();
    test_good();
    test_crc_err();
    test_trunc();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule
